// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/grant and memory bus bundle for mem_arbiter
// lock1 exists only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] adr0;
  logic [AW-1:0] adr1;
  logic [DW-1:0] wd0;
  logic [DW-1:0] wd1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;
`ifdef MEM_ARB_LOCK_EN
  logic          lock1;
`endif
  logic          MemWrite;
  logic [AW-1:0] Adr;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wd0, wd1,
`ifdef MEM_ARB_LOCK_EN
    input  lock1,
`endif
    output gnt0, gnt1, rvalid0, rvalid1, rd0, rd1,
    output MemWrite, Adr, WriteData,
    input  ReadData
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wd0, wd1,
`ifdef MEM_ARB_LOCK_EN
    output lock1,
`endif
    input  gnt0, gnt1, rvalid0, rvalid1, rd0, rd1,
    input  MemWrite, Adr, WriteData,
    output ReadData
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter for a shared unified memory
// Optional port-1 burst lock when MEM_ARB_LOCK_EN is defined.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  if (LOCK_MAX < 2) begin : g_lock_max_check
    $error("mem_arbiter: LOCK_MAX must be at least 2");
  end

  logic          last_q;
  logic          last_d;
  logic          g0;
  logic          g1;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic [DW-1:0] rd0_q;
  logic [DW-1:0] rd1_q;
  logic [AW-1:0] adr_mux;

`ifdef MEM_ARB_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  localparam int CW = $clog2(LOCK_MAX + 1);

  lock_state_t   state_q;
  lock_state_t   state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g0      = 1'b0;
    g1      = 1'b0;
    if (!reset) begin
      case (state_q)
        UNLOCKED: begin
          if (bus.req0 && bus.req1) begin
            g0 = last_q;
            g1 = !last_q;
          end else begin
            g0 = bus.req0;
            g1 = bus.req1;
          end
          if (g1 && bus.lock1) begin
            state_d = LOCKED;
            cnt_d   = CW'(1);
          end
        end
        LOCKED: begin
          // Port 0 is held off for the whole burst.
          g1 = bus.req1;
          if (!bus.req1 || !bus.lock1) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (bus.req0 && bus.req1) begin
        g0 = last_q;
        g1 = !last_q;
      end else begin
        g0 = bus.req0;
        g1 = bus.req1;
      end
    end
  end
`endif

  // A burst ending at LOCK_MAX leaves last = 1, which already hands priority to port 0.
  always_comb begin
    last_d = last_q;
    if (g0) begin
      last_d = 1'b0;
    end else if (g1) begin
      last_d = 1'b1;
    end
  end

  always_comb begin
    adr_mux = '0;
    if (g0) begin
      adr_mux = bus.adr0;
    end else if (g1) begin
      adr_mux = bus.adr1;
    end
  end

  assign bus.gnt0      = g0;
  assign bus.gnt1      = g1;
  assign bus.Adr       = adr_mux;
  assign bus.MemWrite  = (g0 && bus.we0) || (g1 && bus.we1);
  assign bus.WriteData = g0 ? bus.wd0 : (g1 ? bus.wd1 : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rd0_q     <= '0;
      rd1_q     <= '0;
    end else begin
      last_q    <= last_d;
      rvalid0_q <= g0 && !bus.we0;
      rvalid1_q <= g1 && !bus.we1;
      if (g0 && !bus.we0) begin
        rd0_q <= bus.ReadData;
      end
      if (g1 && !bus.we1) begin
        rd1_q <= bus.ReadData;
      end
    end
  end

  // Masking with reset drops a read whose result would land in a reset cycle.
  assign bus.rvalid0 = rvalid0_q && !reset;
  assign bus.rvalid1 = rvalid1_q && !reset;
  assign bus.rd0     = reset ? '0 : rd0_q;
  assign bus.rd1     = reset ? '0 : rd1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a reference model
module tb_mem_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DW-1:0] mem [256];
  assign bus.ReadData = mem[bus.Adr[7:0]];
  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.Adr[7:0]] <= bus.WriteData;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            m_last   = 1;
  bit            m_rv0    = 1'b0;
  bit            m_rv1    = 1'b0;
  logic [DW-1:0] m_rd0    = '0;
  logic [DW-1:0] m_rd1    = '0;
  bit            m_locked = 1'b0;
  int            m_cnt    = 0;
  int            last_win = -1;

  logic          s_gnt0;
  logic          s_gnt1;
  logic          s_memwrite;
  logic [AW-1:0] s_adr;

  int n_checks = 0;
  int n_errors = 0;
  int lock_seq [7];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    int            winner;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    bit            ewe;
    winner = -1;
    if (!reset) begin
      if (m_locked)                     winner = bus.req1 ? 1 : -1;
      else if (bus.req0 && bus.req1)    winner = (m_last == 1) ? 0 : 1;
      else if (bus.req0)                winner = 0;
      else if (bus.req1)                winner = 1;
    end
    ea  = (winner == 0) ? bus.adr0 : (winner == 1) ? bus.adr1 : '0;
    ewd = (winner == 0) ? bus.wd0  : (winner == 1) ? bus.wd1  : '0;
    ewe = (winner == 0) ? bus.we0  : (winner == 1) ? bus.we1  : 1'b0;

    check_eq("gnt0", 64'(bus.gnt0), 64'(winner == 0));
    check_eq("gnt1", 64'(bus.gnt1), 64'(winner == 1));
    check_eq("Adr", 64'(bus.Adr), 64'(ea));
    check_eq("MemWrite", 64'(bus.MemWrite), 64'(ewe));
    check_eq("WriteData", 64'(bus.WriteData), 64'(ewd));
    check_eq("rvalid0", 64'(bus.rvalid0), 64'(reset ? 1'b0 : m_rv0));
    check_eq("rvalid1", 64'(bus.rvalid1), 64'(reset ? 1'b0 : m_rv1));
    check_eq("rd0", 64'(bus.rd0), reset ? 64'd0 : 64'(m_rd0));
    check_eq("rd1", 64'(bus.rd1), reset ? 64'd0 : 64'(m_rd1));

    s_gnt0     = bus.gnt0;
    s_gnt1     = bus.gnt1;
    s_adr      = bus.Adr;
    s_memwrite = bus.MemWrite;
    last_win   = winner;

    if (reset) begin
      m_last = 1; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0; m_locked = 0; m_cnt = 0;
    end else begin
      m_rv0 = (winner == 0) && !ewe;
      m_rv1 = (winner == 1) && !ewe;
      if (m_rv0) m_rd0 = ref_mem[ea[7:0]];
      if (m_rv1) m_rd1 = ref_mem[ea[7:0]];
      if (winner >= 0 && ewe) ref_mem[ea[7:0]] = ewd;
      if (winner >= 0) m_last = winner;
`ifdef MEM_ARB_LOCK_EN
      if (!m_locked) begin
        if (winner == 1 && bus.lock1) begin m_locked = 1; m_cnt = 1; end
      end else if (winner != 1 || !bus.lock1) begin
        m_locked = 0; m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == LOCK_MAX) begin m_locked = 0; m_cnt = 0; m_last = 1; end
      end
`endif
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0 = 0; bus.we0 = 0; bus.adr0 = '0; bus.wd0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.adr1 = '0; bus.wd1 = '0;
`ifdef MEM_ARB_LOCK_EN
    bus.lock1 = 0;
`endif
  endtask

  task automatic set0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0 = r; bus.we0 = w; bus.adr0 = a; bus.wd0 = d;
  endtask

  task automatic set1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1 = r; bus.we1 = w; bus.adr1 = a; bus.wd1 = d;
  endtask

  // A requester keeps its request until granted, then picks a fresh one.
  task automatic drive_random();
    if (!bus.req0 || last_win == 0)
      set0($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 255)), $urandom);
    if (!bus.req1 || last_win == 1)
      set1($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 255)), $urandom);
`ifdef MEM_ARB_LOCK_EN
    bus.lock1 = $urandom_range(0, 3) != 0;
`endif
    reset = $urandom_range(0, 63) == 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[16]     = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    idle();
    reset = 1;
    #1;
    tick();
    tick();
    reset = 0;

    // Single read of 0x10 on port 0
    set0(1, 0, 32'h10, '0);
    tick();
    check_eq("t1_gnt0", 64'(s_gnt0), 64'd1);
    check_eq("t1_rvalid0", 64'(bus.rvalid0), 64'd1);
    check_eq("t1_rd0", 64'(bus.rd0), 64'hDEADBEEF);
    idle();
    tick();
    check_eq("t1_rvalid0_pulse", 64'(bus.rvalid0), 64'd0);
    check_eq("t1_rd0_hold", 64'(bus.rd0), 64'hDEADBEEF);

    // Continuous contention right after reset
    reset = 1;
    tick();
    reset = 0;
    set0(1, 0, 32'h40, '0);
    set1(1, 0, 32'h80, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t2_gnt0_%0d", k), 64'(s_gnt0), 64'((k % 2) == 0));
      check_eq($sformatf("t2_one_hot_%0d", k), 64'(s_gnt0 & s_gnt1), 64'd0);
      check_eq($sformatf("t2_adr_%0d", k), 64'(s_adr), (k % 2 == 0) ? 64'h40 : 64'h80);
    end

    // Port 1 write then port 0 readback
    idle();
    set1(1, 1, 32'h20, 32'h1234);
    tick();
    check_eq("t3_memwrite_w", 64'(s_memwrite), 64'd1);
    idle();
    set0(1, 0, 32'h20, '0);
    tick();
    check_eq("t3_memwrite_r", 64'(s_memwrite), 64'd0);
    check_eq("t3_rd0", 64'(bus.rd0), 64'h1234);
    check_eq("t3_rvalid1", 64'(bus.rvalid1), 64'd0);

    // Reset in the cycle after a granted read
    set0(1, 0, 32'h10, '0);
    tick();
    idle();
    reset = 1;
    #1;
    check_eq("t4_rvalid0", 64'(bus.rvalid0), 64'd0);
    check_eq("t4_rd0", 64'(bus.rd0), 64'd0);
    tick();
    reset = 0;
    set0(1, 0, 32'h40, '0);
    set1(1, 0, 32'h80, '0);
    tick();
    check_eq("t4_first_gnt0", 64'(s_gnt0), 64'd1);
    idle();
    tick();

`ifdef MEM_ARB_LOCK_EN
    // Held lock: one port-0 grant, LOCK_MAX port-1 grants, then port 0 again
    lock_seq = '{0, 1, 1, 1, 1, 0, 1};
    reset = 1;
    tick();
    reset = 0;
    set0(1, 0, 32'h1, '0);
    set1(1, 0, 32'h2, '0);
    bus.lock1 = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq($sformatf("lock_seq_%0d", k), 64'(s_gnt1), 64'(lock_seq[k]));
    end

    // lock1 dropped after two locked grants
    reset = 1;
    tick();
    reset = 0;
    tick();
    tick();
    tick();
    bus.lock1 = 0;
    tick();
    tick();
    check_eq("lock_drop_gnt0", 64'(s_gnt0), 64'd1);
    idle();
    tick();
`endif

    reset = 0;
    for (int n = 0; n < 400; n++) begin
      drive_random();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
